// File: rtl/wired_rob.sv
// wired_rob: in-order reorder buffer for the 2-wide commit stage.
//   Dispatch allocates up to two entries per cycle at the tail, two CDB lanes
//   mark entries done and store results, commit reads two entries
//   combinationally and retires up to two per cycle from the head. A flush
//   discards every entry that is not retired in the same cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   d_valid_i/d_done_i/d_entry_i   dispatch lanes (00/01/11), done-at-allocate, payload
//   d_ready_o, d_rid_o             at least two free slots; rids {tail+1, tail}
//   cdb_valid_i/cdb_rid_i/cdb_data_i  result writeback lanes
//   c_rrrid_i                      commit read addresses (lane1 = lane0+1)
//   c_rob_valid_o/c_rob_entry_o/c_rob_wdata_o  occupied&done flag, payload, result
//   c_retire_i, flush_i, count_o   retire head entries, discard all, occupancy
module wired_rob #(
  parameter int ROB_DEPTH = 64,
  parameter int PAYLOAD_W = 128,
  parameter int DATA_W    = 32,
  localparam int RID_W    = $clog2(ROB_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 d_valid_i,
  input  logic [1:0]                 d_done_i,
  input  logic [1:0][PAYLOAD_W-1:0]  d_entry_i,
  output logic                       d_ready_o,
  output logic [1:0][RID_W-1:0]      d_rid_o,
  input  logic [1:0]                 cdb_valid_i,
  input  logic [1:0][RID_W-1:0]      cdb_rid_i,
  input  logic [1:0][DATA_W-1:0]     cdb_data_i,
  input  logic [1:0][RID_W-1:0]      c_rrrid_i,
  output logic [1:0]                 c_rob_valid_o,
  output logic [1:0][PAYLOAD_W-1:0]  c_rob_entry_o,
  output logic [1:0][DATA_W-1:0]     c_rob_wdata_o,
  input  logic [1:0]                 c_retire_i,
  input  logic                       flush_i,
  output logic [RID_W:0]             count_o
);

  localparam logic [RID_W+1:0] DEPTH_EXT = (RID_W+2)'(ROB_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [RID_W:0]          head_q, tail_q, head_next, tail_next, count;
  logic [ROB_DEPTH-1:0]    done_q, done_next;
  logic [PAYLOAD_W-1:0]    payload_q [ROB_DEPTH];
  logic [DATA_W-1:0]       data_q    [ROB_DEPTH];

  logic [RID_W-1:0]        head_lo, head_lo1, tail_lo, tail_lo1;
  logic [RID_W+1:0]        free_cnt;
  logic                    fire;
  logic [1:0]              alloc, alloc_cnt, ret_cnt;
  logic [1:0]              cdb_hit;

  function automatic logic occupied(input logic [RID_W-1:0] rid);
    logic [RID_W-1:0] off;
    off = rid - head_q[RID_W-1:0];
    return {1'b0, off} < count;
  endfunction

  assign count     = tail_q - head_q;
  assign count_o   = count;
  assign free_cnt  = DEPTH_EXT - {1'b0, count};
  // Ready looks only at registered occupancy; a same-cycle retire cannot raise it.
  assign d_ready_o = free_cnt >= (RID_W+2)'(2);

  assign head_lo  = head_q[RID_W-1:0];
  assign head_lo1 = head_lo + RID_W'(1);
  assign tail_lo  = tail_q[RID_W-1:0];
  assign tail_lo1 = tail_lo + RID_W'(1);
  assign d_rid_o  = {tail_lo1, tail_lo};

  assign fire      = d_ready_o & ~flush_i;
  assign alloc     = d_valid_i & {2{fire}};
  assign alloc_cnt = {1'b0, alloc[0]} + {1'b0, alloc[1]};
  assign ret_cnt   = {1'b0, c_retire_i[0]} + {1'b0, c_retire_i[1]};

  assign head_next = head_q + {{(RID_W-1){1'b0}}, ret_cnt};
  // Flush still honours the same-cycle retire, then collapses the tail onto it.
  assign tail_next = flush_i ? head_next : tail_q + {{(RID_W-1){1'b0}}, alloc_cnt};

  assign cdb_hit[0] = cdb_valid_i[0] & occupied(cdb_rid_i[0]);
  assign cdb_hit[1] = cdb_valid_i[1] & occupied(cdb_rid_i[1]);

  always_comb begin
    done_next = done_q;
    if (c_retire_i[0]) done_next[head_lo]  = 1'b0;
    if (c_retire_i[1]) done_next[head_lo1] = 1'b0;
    if (cdb_hit[0]) done_next[cdb_rid_i[0]] = 1'b1;
    if (cdb_hit[1]) done_next[cdb_rid_i[1]] = 1'b1;
    if (alloc[0]) done_next[tail_lo]  = d_done_i[0];
    if (alloc[1]) done_next[tail_lo1] = d_done_i[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_next;
      tail_q <= tail_next;
      done_q <= flush_i ? '0 : done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc[0]) payload_q[tail_lo]  <= d_entry_i[0];
    if (alloc[1]) payload_q[tail_lo1] <= d_entry_i[1];
    if (cdb_hit[0]) data_q[cdb_rid_i[0]] <= cdb_data_i[0];
    if (cdb_hit[1]) data_q[cdb_rid_i[1]] <= cdb_data_i[1];
  end

  // No CDB bypass: a result becomes visible the cycle after its write.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      c_rob_valid_o[i] = done_q[c_rrrid_i[i]] & occupied(c_rrrid_i[i]);
      c_rob_entry_o[i] = payload_q[c_rrrid_i[i]];
      c_rob_wdata_o[i] = data_q[c_rrrid_i[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (d_valid_i != 2'b10);
      assert (c_retire_i != 2'b10);
      assert (!(cdb_valid_i == 2'b11 && cdb_rid_i[0] == cdb_rid_i[1]));
      assert (!c_retire_i[0] || (c_rob_valid_o[0] && c_rrrid_i[0] == head_lo));
      assert (!c_retire_i[1] || c_rob_valid_o[1]);
    end
  end

endmodule

// File: tb/tb_wired_rob.sv
module tb_wired_rob;
  localparam int DEPTH = 64;
  localparam int PW    = 128;
  localparam int DW    = 32;
  localparam int RW    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]          d_valid, d_done;
  logic [1:0][PW-1:0]  d_entry;
  logic                d_ready;
  logic [1:0][RW-1:0]  d_rid;
  logic [1:0]          cdb_valid;
  logic [1:0][RW-1:0]  cdb_rid;
  logic [1:0][DW-1:0]  cdb_data;
  logic [1:0][RW-1:0]  c_rrrid;
  logic [1:0]          c_valid;
  logic [1:0][PW-1:0]  c_entry;
  logic [1:0][DW-1:0]  c_wdata;
  logic [1:0]          c_retire;
  logic                flush;
  logic [RW:0]         count;

  always #5 clk = ~clk;

  wired_rob #(.ROB_DEPTH(DEPTH), .PAYLOAD_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_valid_i(d_valid), .d_done_i(d_done), .d_entry_i(d_entry),
    .d_ready_o(d_ready), .d_rid_o(d_rid),
    .cdb_valid_i(cdb_valid), .cdb_rid_i(cdb_rid), .cdb_data_i(cdb_data),
    .c_rrrid_i(c_rrrid), .c_rob_valid_o(c_valid), .c_rob_entry_o(c_entry),
    .c_rob_wdata_o(c_wdata), .c_retire_i(c_retire), .flush_i(flush),
    .count_o(count)
  );

  // Reference model: the ROB is a FIFO of live entries; head_abs is an
  // unbounded retire counter, so entry k has rid (head_abs+k) mod DEPTH.
  typedef struct {
    logic [PW-1:0] payload;
    logic [DW-1:0] data;
    bit            done;
    bit            data_ok;
  } ent_t;

  ent_t q[$];
  int   head_abs = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_valid = 2'b00; d_done = 2'b00; d_entry = '0;
    cdb_valid = 2'b00; cdb_rid = '0; cdb_data = '0;
    c_retire = 2'b00; flush = 1'b0;
  endtask

  function automatic int offset_of(input int rid);
    return (rid - (head_abs % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic model_check();
    int sz;
    sz = q.size();
    chk("count", 128'(count), 128'(sz));
    chk("ready", 128'(d_ready), 128'((DEPTH - sz) >= 2));
    chk("rid0", 128'(d_rid[0]), 128'((head_abs + sz) % DEPTH));
    chk("rid1", 128'(d_rid[1]), 128'((head_abs + sz + 1) % DEPTH));
    for (int i = 0; i < 2; i++) begin
      int off;
      bit exp_v;
      off = offset_of(int'(c_rrrid[i]));
      exp_v = (off < sz) && q[off].done;
      chk($sformatf("cvalid%0d", i), 128'(c_valid[i]), 128'(exp_v));
      if (off < sz) chk($sformatf("centry%0d", i), c_entry[i], q[off].payload);
      if (exp_v && q[off].data_ok) chk($sformatf("cwdata%0d", i), 128'(c_wdata[i]), 128'(q[off].data));
    end
  endtask

  task automatic model_update();
    int sz;
    bit rdy;
    sz = q.size();
    rdy = (DEPTH - sz) >= 2;
    for (int i = 0; i < 2; i++) begin
      if (cdb_valid[i]) begin
        int off;
        off = offset_of(int'(cdb_rid[i]));
        if (off < sz) begin
          q[off].done = 1'b1;
          q[off].data = cdb_data[i];
          q[off].data_ok = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (c_retire[i]) begin
        void'(q.pop_front());
        head_abs++;
      end
    end
    if (flush) q.delete();
    else if (rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (d_valid[i]) begin
          ent_t e;
          e.payload = d_entry[i]; e.data = '0; e.done = d_done[i]; e.data_ok = 1'b0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic pre();
    c_rrrid[0] = RW'(head_abs % DEPTH);
    c_rrrid[1] = RW'((head_abs + 1) % DEPTH);
    @(negedge clk);
    model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    head_abs = 0;
    idle();
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 2; i++)
      d_entry[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_dispatch();
    int r;
    r = $urandom_range(2);
    d_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    d_done = 2'($urandom);
    rand_payload();
  endtask

  task automatic rand_cdb(input int prob);
    int idx[$];
    cdb_valid = 2'b00;
    foreach (q[k]) if (!q[k].done) idx.push_back(k);
    for (int i = 0; i < 2; i++) begin
      cdb_data[i] = $urandom;
      if (idx.size() > 0 && $urandom_range(99) < prob) begin
        int p;
        p = $urandom_range(idx.size() - 1);
        cdb_valid[i] = 1'b1;
        cdb_rid[i] = RW'((head_abs + idx[p]) % DEPTH);
        idx.delete(p);
      end else if (q.size() < DEPTH && $urandom_range(9) == 0) begin
        // write to a free slot: must be ignored
        cdb_valid[i] = 1'b1;
        cdb_rid[i] = RW'((head_abs + q.size() + $urandom_range(DEPTH - q.size() - 1)) % DEPTH);
        if (i == 1 && cdb_valid[0] && cdb_rid[0] == cdb_rid[1]) cdb_valid[1] = 1'b0;
      end
    end
  endtask

  task automatic rand_retire(input bit eager);
    c_retire = 2'b00;
    if (q.size() > 0 && q[0].done && (eager || $urandom_range(3) != 0)) begin
      c_retire = 2'b01;
      if (q.size() > 1 && q[1].done && (eager || $urandom_range(1) == 1)) c_retire = 2'b11;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      idle();
      rand_cdb(100);
      rand_retire(1'b1);
      cycle();
      n++;
    end
    chk("drain_timeout", 128'(q.size()), 128'(0));
    idle();
  endtask

  initial begin
    idle();
    c_rrrid = '0;
    do_reset();

    // reset state
    pre();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ready", 128'(d_ready), 128'(1));
    chk("rst_valid", 128'(c_valid), 128'(0));
    post();

    // fill: 32 dual dispatches reach full
    for (int k = 0; k < 32; k++) begin
      d_valid = 2'b11; d_done = 2'b00; rand_payload();
      pre();
      chk("fill_rid0", 128'(d_rid[0]), 128'(2 * k));
      post();
    end
    d_valid = 2'b11; rand_payload();
    pre();
    chk("full_count", 128'(count), 128'(64));
    chk("full_ready", 128'(d_ready), 128'(0));
    post();
    drain();

    // CDB ordering: rid1 first, then rid0
    d_valid = 2'b11; d_done = 2'b00; rand_payload();
    cycle();
    idle();
    cdb_valid = 2'b10; cdb_rid[1] = RW'((head_abs + 1) % DEPTH); cdb_data[1] = 32'hA5A5_0001;
    cycle();
    idle();
    pre();
    chk("cdb1_valid", 128'(c_valid), 128'(2'b10));
    post();
    cdb_valid = 2'b01; cdb_rid[0] = RW'(head_abs % DEPTH); cdb_data[0] = 32'h5A5A_0000;
    cycle();
    idle();
    pre();
    chk("cdb0_valid", 128'(c_valid), 128'(2'b11));
    post();
    c_retire = 2'b11;
    cycle();
    idle();
    pre();
    chk("ret_count", 128'(count), 128'(0));
    post();

    // wrap: walk head and tail to slot 63
    for (int n = 0; n < 300 && !(q.size() == 0 && head_abs % DEPTH == 63); n++) begin
      idle();
      if ((head_abs + q.size()) % DEPTH != 63) begin
        d_valid = 2'b01; d_done = 2'b01; rand_payload();
      end
      rand_retire(1'b1);
      cycle();
    end
    chk("wrap_head", 128'(head_abs % DEPTH), 128'(63));
    idle();
    d_valid = 2'b11; d_done = 2'b00; rand_payload();
    pre();
    chk("wrap_rid", 128'(d_rid), 128'({6'd0, 6'd63}));
    post();
    idle();
    cdb_valid = 2'b11; cdb_rid[0] = 6'd63; cdb_rid[1] = 6'd0;
    cdb_data[0] = 32'h0000_0063; cdb_data[1] = 32'h0000_0100;
    cycle();
    idle();
    c_retire = 2'b11;
    pre();
    chk("wrap_valid", 128'(c_valid), 128'(2'b11));
    post();
    idle();
    pre();
    chk("wrap_count", 128'(count), 128'(0));
    post();

    // flush with a same-cycle retire; done-at-allocate entries
    for (int k = 0; k < 5; k++) begin
      d_valid = 2'b11; d_done = 2'b11; rand_payload();
      cycle();
    end
    idle();
    flush = 1'b1; c_retire = 2'b01; d_valid = 2'b11; rand_payload();
    pre();
    chk("pre_flush_count", 128'(count), 128'(10));
    chk("done_alloc_valid", 128'(c_valid), 128'(2'b11));
    post();
    idle();
    pre();
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(c_valid), 128'(2'b00));
    post();

    // near full: dispatch and retire together
    for (int k = 0; k < 31; k++) begin
      d_valid = 2'b11; d_done = 2'b11; rand_payload();
      cycle();
    end
    d_valid = 2'b11; d_done = 2'b11; rand_payload(); c_retire = 2'b11;
    pre();
    chk("f62_ready", 128'(d_ready), 128'(1));
    post();
    idle();
    pre();
    chk("f62_count", 128'(count), 128'(62));
    post();

    // reset while retiring
    c_retire = 2'b11; d_valid = 2'b11;
    do_reset();
    pre();
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_valid", 128'(c_valid), 128'(0));
    chk("mid_rst_ready", 128'(d_ready), 128'(1));
    post();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rand_dispatch();
      rand_cdb(60);
      rand_retire(1'b0);
      flush = ($urandom_range(63) == 0);
      cycle();
    end
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
